// File: rtl/keypad_pkg.sv
// Shared key codes and FSM encoding for keypad operand entry.
// Imported by the entry controller and its converter.
package keypad_pkg;

   localparam logic [3:0] KEY_NEG   = 4'd10;
   localparam logic [3:0] KEY_ENTER = 4'd11;
   localparam logic [3:0] KEY_CLR   = 4'd12;

   typedef enum logic [1:0] {
      ENTRY_A,
      ENTRY_B,
      CONVERT,
      PRESENT
   } state_t;

   function automatic logic is_digit(input logic [3:0] k);
      return k <= 4'd9;
   endfunction

endpackage

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD to signed binary converter, one digit per cycle,
// most-significant digit first, multiply by ten with shifts only.
module bcd_to_bin_seq
   import keypad_pkg::*;
#(
   parameter int NUM_DIGITS = 3,
   parameter int OUT_W      = 12,
   parameter int CNT_W      = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [4*NUM_DIGITS-1:0] bcd,
   input  logic [CNT_W-1:0]        count,
   input  logic                    neg,
   output logic                    done,
   output logic [OUT_W-1:0]        result
);

   logic             busy_q, busy_d;
   logic [CNT_W-1:0] idx_q, idx_d;
   logic [OUT_W-1:0] acc_q, acc_d;
   logic [3:0]       digit;
   logic [OUT_W-1:0] acc_nxt;

   // Accumulate current digit; last digit produces signed result.
   always_comb begin
      busy_d  = busy_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      digit   = 4'(bcd >> (4 * idx_q));
      acc_nxt = (acc_q << 3) + (acc_q << 1) + OUT_W'(digit);
      done    = busy_q && (idx_q == '0);
      result  = neg ? -acc_nxt : acc_nxt;
      if (start) begin
         busy_d = 1'b1;
         idx_d  = count - 1'b1;
         acc_d  = '0;
      end else if (busy_q) begin
         acc_d = acc_nxt;
         if (idx_q == '0)
            busy_d = 1'b0;
         else
            idx_d = idx_q - 1'b1;
      end
   end

   // Converter registers; reset discards a partial conversion.
   always_ff @(posedge clk) begin
      if (!rst) begin
         busy_q <= 1'b0;
         idx_q  <= '0;
         acc_q  <= '0;
      end else begin
         busy_q <= busy_d;
         idx_q  <= idx_d;
         acc_q  <= acc_d;
      end
   end

endmodule

// File: rtl/keypad_operand_ctrl.sv
// Keypad operand entry FSM: builds signed decimal operands A and B
// and presents the pair downstream on a valid/ready handshake.
module keypad_operand_ctrl
   import keypad_pkg::*;
#(
   parameter int NUM_DIGITS = 3,
   parameter int OUT_W      = 12
) (
   input  logic                    clk_div,
   input  logic                    rst,
   input  logic [3:0]              num,
   input  logic                    load_num,
   output logic [OUT_W-1:0]        op_a,
   output logic [OUT_W-1:0]        op_b,
   output logic                    op_valid,
   input  logic                    op_ready,
   output logic [4*NUM_DIGITS-1:0] entry_bcd,
   output logic                    entry_neg,
   output logic                    entry_sel,
   output logic                    key_err
);

   localparam int CNT_W = $clog2(NUM_DIGITS + 1);
   localparam int BCD_W = 4 * NUM_DIGITS;

   state_t           state_q, state_d;
   logic [BCD_W-1:0] bcd_q, bcd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             neg_q, neg_d;
   logic             sel_q, sel_d;
   logic             err_q, err_d;
   logic [OUT_W-1:0] op_a_q, op_a_d;
   logic [OUT_W-1:0] op_b_q, op_b_d;
   logic             conv_start;
   logic             conv_done;
   logic [OUT_W-1:0] conv_res;

   bcd_to_bin_seq #(
      .NUM_DIGITS(NUM_DIGITS),
      .OUT_W     (OUT_W),
      .CNT_W     (CNT_W)
   ) u_conv (
      .clk   (clk_div),
      .rst   (rst),
      .start (conv_start),
      .bcd   (bcd_q),
      .count (cnt_q),
      .neg   (neg_q),
      .done  (conv_done),
      .result(conv_res)
   );

   // Next state: key decode in entry states, writeback, handshake.
   always_comb begin
      state_d    = state_q;
      bcd_d      = bcd_q;
      cnt_d      = cnt_q;
      neg_d      = neg_q;
      sel_d      = sel_q;
      err_d      = 1'b0;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      conv_start = 1'b0;
      unique case (state_q)
         ENTRY_A, ENTRY_B: begin
            if (load_num) begin
               unique case (1'b1)
                  is_digit(num): begin
                     if (cnt_q == CNT_W'(NUM_DIGITS)) begin
                        err_d = 1'b1;
                     end else begin
                        bcd_d = BCD_W'({bcd_q, num});
                        cnt_d = cnt_q + 1'b1;
                     end
                  end
                  (num == KEY_NEG): neg_d = ~neg_q;
                  (num == KEY_ENTER): begin
                     if (cnt_q == '0) begin
                        err_d = 1'b1;
                     end else begin
                        state_d    = CONVERT;
                        conv_start = 1'b1;
                     end
                  end
                  (num == KEY_CLR): begin
                     if (cnt_q != '0 || neg_q) begin
                        bcd_d = '0;
                        cnt_d = '0;
                        neg_d = 1'b0;
                     end else if (state_q == ENTRY_B) begin
                        state_d = ENTRY_A;
                        sel_d   = 1'b0;
                        op_a_d  = '0;
                     end
                  end
                  default: ;
               endcase
            end
         end
         CONVERT: begin
            if (conv_done) begin
               bcd_d = '0;
               cnt_d = '0;
               neg_d = 1'b0;
               if (sel_q) begin
                  op_b_d  = conv_res;
                  state_d = PRESENT;
               end else begin
                  op_a_d  = conv_res;
                  sel_d   = 1'b1;
                  state_d = ENTRY_B;
               end
            end
         end
         PRESENT: begin
            if (op_ready) begin
               state_d = ENTRY_A;
               sel_d   = 1'b0;
            end
         end
         default: state_d = ENTRY_A;
      endcase
   end

   // State and entry registers with synchronous active-low reset.
   always_ff @(posedge clk_div) begin
      if (!rst) begin
         state_q <= ENTRY_A;
         bcd_q   <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         sel_q   <= 1'b0;
         err_q   <= 1'b0;
         op_a_q  <= '0;
         op_b_q  <= '0;
      end else begin
         state_q <= state_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         sel_q   <= sel_d;
         err_q   <= err_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
      end
   end

   assign op_a      = op_a_q;
   assign op_b      = op_b_q;
   assign op_valid  = (state_q == PRESENT);
   assign entry_bcd = bcd_q;
   assign entry_neg = neg_q;
   assign entry_sel = sel_q;
   assign key_err   = err_q;

endmodule
